trig_irq_ctrl: RTL

//  Downstream consumer of the timer/comparator 'trig' output. Detects trig rising edges,

---
 rtl/trig_irq_ctrl_pkg.sv | 29 ++
 rtl/trig_irq_ctrl_if.sv | 25 ++
 rtl/trig_edge_sync.sv | 31 +++
 rtl/trig_irq_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/trig_irq_ctrl_pkg.sv
// Shared definitions for trig_irq_ctrl: register addresses, CTRL/STATUS bit
// indices, pulse FSM state encodings and the threshold normalisation helper.
package trig_irq_ctrl_pkg;

  // Register word addresses
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_THRESH = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // CTRL bit indices
  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_IE   = 1;
  localparam int unsigned CTRL_MODE = 2;

  // STATUS bit indices
  localparam int unsigned STAT_PEND = 0;
  localparam int unsigned STAT_OVF  = 1;

  // Pulse FSM state encodings
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_PULSE = 1'b1;

  // A programmed threshold of 0 behaves as 1.
  function automatic logic [7:0] eff_thresh(input logic [7:0] t);
    return (t == '0) ? 8'd1 : t;
  endfunction

endpackage

// File: rtl/trig_irq_ctrl_if.sv
// APB slave bus bundle for trig_irq_ctrl.
//  PSEL/PENABLE/PWRITE  transfer control (master -> slave)
//  PADDR[1:0]           register word index
//  PWDATA[7:0]          write data
//  PRDATA[7:0]          read data (slave -> master)
//  PREADY               always 1, zero wait states
interface trig_irq_ctrl_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [1:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/trig_edge_sync.sv
// Synchroniser plus rising-edge detector for a level arriving from another
// clock domain.
//  clk   in  sampling clock
//  rst   in  synchronous active-high reset, clears chain and edge history
//  din   in  asynchronous level
//  rise  out one-cycle pulse when the synchronised level goes 0->1
module trig_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~s_d;

endmodule

// File: rtl/trig_irq_ctrl.sv
// Trigger interrupt controller. Counts synchronised rising edges of trig
// against a programmable threshold, latches a pending/overflow status,
// raises a maskable level interrupt and stretches each terminal event into
// a PULSE_W-cycle trig_out pulse. Configured over an APB slave port.
//  PCLK      in  clock
//  PRESET    in  synchronous active-high reset
//  apb       APB slave bundle (PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA, PREADY)
//  trig      in  asynchronous trigger level
//  irq       out PEND & IE
//  trig_out  out stretched pulse per terminal event
module trig_irq_ctrl
  import trig_irq_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PULSE_W     = 4
) (
  input  logic              PCLK,
  input  logic              PRESET,
  trig_irq_ctrl_if.slave    apb,
  input  logic              trig,
  output logic              irq,
  output logic              trig_out
);

  localparam int unsigned CNT_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  logic             en_q, ie_q, mode_q;
  logic [7:0]       thresh_q, count_q;
  logic             pend_q, ovf_q;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trig_out_q;

  logic             rise;
  logic             wr_en, wr_ctrl, wr_thresh, wr_status;
  logic             disable_now;
  logic [7:0]       count_inc;
  logic             hit;
  logic             terminal;
  logic             clr_pend, clr_ovf;
  logic [7:0]       rdata;

  trig_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (PCLK),
    .rst  (PRESET),
    .din  (trig),
    .rise (rise)
  );

  assign wr_en     = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign wr_ctrl   = wr_en & (apb.PADDR == ADDR_CTRL);
  assign wr_thresh = wr_en & (apb.PADDR == ADDR_THRESH);
  assign wr_status = wr_en & (apb.PADDR == ADDR_STATUS);

  // Clearing EN flushes the counter and the pulse on the same edge.
  assign disable_now = wr_ctrl & ~apb.PWDATA[CTRL_EN];

  assign count_inc = count_q + 8'd1;
  // >= so that a threshold lowered below COUNT fires on the next edge.
  assign hit       = count_inc >= eff_thresh(thresh_q);
  assign terminal  = rise & en_q & (~mode_q | hit);

  assign clr_pend  = wr_status & apb.PWDATA[STAT_PEND];
  assign clr_ovf   = wr_status & apb.PWDATA[STAT_OVF];

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      mode_q   <= 1'b0;
      thresh_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en_q   <= apb.PWDATA[CTRL_EN];
        ie_q   <= apb.PWDATA[CTRL_IE];
        mode_q <= apb.PWDATA[CTRL_MODE];
      end
      if (wr_thresh) thresh_q <= apb.PWDATA;

      if (disable_now)
        count_q <= '0;
      else if (rise & en_q & mode_q)
        count_q <= hit ? '0 : count_inc;

      // Set beats clear; an acknowledged PEND does not count as overflow.
      pend_q <= (pend_q & ~clr_pend) | terminal;
      ovf_q  <= (ovf_q & ~clr_ovf) | (terminal & pend_q & ~clr_pend);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (disable_now) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (terminal) begin
      state_d = ST_PULSE;
      cnt_d   = CNT_W'(PULSE_W - 1);
    end else if (state_q == ST_PULSE) begin
      if (cnt_q == '0) state_d = ST_IDLE;
      else             cnt_d   = cnt_q - CNT_W'(1);
    end
  end

  // trig_out is registered alongside the state so it mirrors PULSE exactly.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      trig_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      trig_out_q <= (state_d == ST_PULSE);
    end
  end

  always_comb begin
    rdata = '0;
    if (apb.PSEL & ~apb.PWRITE) begin
      unique case (apb.PADDR)
        ADDR_CTRL:   rdata = {5'b0, mode_q, ie_q, en_q};
        ADDR_THRESH: rdata = thresh_q;
        ADDR_COUNT:  rdata = count_q;
        ADDR_STATUS: rdata = {6'b0, ovf_q, pend_q};
        default:     rdata = '0;
      endcase
    end
  end

  assign apb.PRDATA = rdata;
  assign apb.PREADY = 1'b1;
  assign irq        = pend_q & ie_q;
  assign trig_out   = trig_out_q;

endmodule
